// File: rtl/peri_serial_tx.sv
// Serial transmitter with a programmable clock divider, clock polarity, bit order and
// one-of-N active-low chip selects.
module peri_serial_tx #(
    parameter int DATA_W    = 16,
    parameter int DIV       = 4,
    parameter int NUM_CS    = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit CPOL      = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        cs_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              P_CLOCK,
    output logic              P_DATA,
    output logic [NUM_CS-1:0] P_CS
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, LEAD, BIT_IDLE, BIT_ACT, TRAIL} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shift_q;
    logic [2:0]         cs_q;
    logic               div_last;
    logic               bit_last;
    logic               cs_ok;
    logic               load;
    logic               shift;
    logic               done_nxt;
    logic               err_nxt;

    assign div_last = (div_cnt == DIV_W'(DIV - 1));
    assign bit_last = (bit_cnt == BIT_W'(DATA_W - 1));
    assign cs_ok    = ({1'b0, cs_sel} < 4'(NUM_CS));
    // The next bit is presented exactly when BIT_ACT hands over to BIT_IDLE.
    assign shift    = (state == BIT_ACT) && div_last && !bit_last;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cs_ok) begin
                        state_nxt = LEAD;
                        load      = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            LEAD:     if (div_last) state_nxt = BIT_IDLE;
            BIT_IDLE: if (div_last) state_nxt = BIT_ACT;
            BIT_ACT:  if (div_last) state_nxt = bit_last ? TRAIL : BIT_IDLE;
            TRAIL: begin
                if (div_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            if (state == IDLE || div_last) div_cnt <= '0;
            else                           div_cnt <= div_cnt + 1'b1;
            if (state == IDLE) bit_cnt <= '0;
            else if (shift)    bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Payload and CS index are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clock) begin
        if (load) begin
            shift_q <= data_in;
            cs_q    <= cs_sel;
        end else if (shift) begin
            shift_q <= MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};
        end
    end

    assign busy    = (state != IDLE);
    assign P_CLOCK = (state == BIT_ACT) ? ~CPOL : CPOL;
    assign P_DATA  = busy ? (MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0]) : 1'b0;

    always_comb begin
        P_CS = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (busy && cs_q == 3'(i)) P_CS[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_peri_serial_tx.sv
// Scoreboard bench for peri_serial_tx: two configurations driven with directed and random
// transfers, a passive monitor reassembles each serial word and checks it against the queue.
module tb_peri_serial_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2];
    logic        start[2];
    logic [2:0]  csel[2];
    logic [15:0] din_a;
    logic [7:0]  din_b;
    logic        busy[2], done[2], err[2], pclk[2], pdata[2];
    logic [3:0]  pcs[2];

    peri_serial_tx #(.DATA_W(16), .DIV(2), .NUM_CS(4), .MSB_FIRST(1'b1), .CPOL(1'b0)) dut_a (
        .clock(clk), .reset(rst[0]), .start(start[0]), .data_in(din_a), .cs_sel(csel[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .P_CLOCK(pclk[0]), .P_DATA(pdata[0]),
        .P_CS(pcs[0]));

    peri_serial_tx #(.DATA_W(8), .DIV(1), .NUM_CS(4), .MSB_FIRST(1'b0), .CPOL(1'b1)) dut_b (
        .clock(clk), .reset(rst[1]), .start(start[1]), .data_in(din_b), .cs_sel(csel[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .P_CLOCK(pclk[1]), .P_DATA(pdata[1]),
        .P_CS(pcs[1]));

    function automatic int dw(input int k);       return (k == 0) ? 16 : 8; endfunction
    function automatic int dv(input int k);       return (k == 0) ? 2 : 1; endfunction
    function automatic logic cpol(input int k);   return (k == 0) ? 1'b0 : 1'b1; endfunction
    function automatic bit msb(input int k);      return (k == 0); endfunction
    function automatic int xfer_len(input int k); return dv(k) * (2 * dw(k) + 2); endfunction

    typedef struct {
        int     k;
        longint word;
        int     cs;
        bit     abort;
        int     gap;
    } rec_t;

    rec_t sbq[$];
    int   exp_err[2];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(input string nm, input int k, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endfunction

    // Expected word is the request truncated to the configured width.
    function automatic void expect_xfer(input int k, input logic [15:0] d, input int cs,
                                        input bit abort, input int gap);
        longint w;
        w = (k == 0) ? longint'(d) : longint'(d[7:0]);
        sbq.push_back('{k: k, word: w, cs: cs, abort: abort, gap: gap});
    endfunction

    task automatic set_in(input int k, input logic [15:0] d, input logic [2:0] cs);
        if (k == 0) din_a = d;
        else        din_b = d[7:0];
        csel[k] = cs;
    endtask

    task automatic send(input int k, input logic [15:0] d, input logic [2:0] cs);
        @(posedge clk); #1;
        start[k] = 1'b1;
        set_in(k, d, cs);
        if (cs < 3'd4) expect_xfer(k, d, int'(cs), 1'b0, -1);
        else           exp_err[k]++;
        @(posedge clk); #1;
        start[k] = 1'b0;
        repeat (xfer_len(k) + 3) @(posedge clk);
    endtask

    task automatic back_to_back(input int k, input int n);
        logic [15:0] d;
        logic [2:0]  cs;
        @(posedge clk); #1;
        start[k] = 1'b1;
        for (int i = 0; i < n; i++) begin
            d  = 16'($urandom);
            cs = 3'($urandom_range(0, 3));
            set_in(k, d, cs);
            expect_xfer(k, d, int'(cs), 1'b0, (i > 0) ? 1 : -1);
            repeat (xfer_len(k) + 1) @(posedge clk);
            #1;
        end
        start[k] = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    // Monitor state, one slot per DUT.
    bit     in_x[2];
    int     bcnt[2], nb[2], csi[2], idle_run[2], gapm[2];
    longint word[2];
    bit     csbad[2];
    logic   prevc[2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int   lows;
            int   li;
            int   f;
            bit   ended;
            rec_t r;
            lows  = 0;
            li    = -1;
            ended = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (!pcs[k][j]) begin
                    lows++;
                    if (li < 0) li = j;
                end
            end
            if (busy[k] && !in_x[k]) begin
                in_x[k]  = 1'b1;
                bcnt[k]  = 0;
                nb[k]    = 0;
                word[k]  = 0;
                csi[k]   = li;
                csbad[k] = 1'b0;
                gapm[k]  = idle_run[k];
            end
            if (in_x[k] && busy[k]) begin
                bcnt[k]++;
                if (lows != 1 || li != csi[k]) csbad[k] = 1'b1;
                if (prevc[k] == cpol(k) && pclk[k] != cpol(k)) begin
                    if (msb(k)) word[k] = (word[k] << 1) | longint'(pdata[k]);
                    else        word[k] = word[k] | (longint'(pdata[k]) << nb[k]);
                    nb[k]++;
                end
            end else if (in_x[k] && !busy[k]) begin
                ended   = 1'b1;
                in_x[k] = 1'b0;
                f = -1;
                for (int i = 0; i < sbq.size(); i++) if (f < 0 && sbq[i].k == k) f = i;
                chk("sb_match", k, longint'(f >= 0), 1);
                if (f >= 0) begin
                    r = sbq[f];
                    sbq.delete(f);
                    chk("idle_pclk", k, pclk[k], cpol(k));
                    chk("idle_pdata", k, pdata[k], 0);
                    chk("idle_cs", k, pcs[k], 4'hF);
                    if (r.abort) begin
                        chk("abort_done", k, done[k], 0);
                    end else begin
                        chk("done", k, done[k], 1);
                        chk("word", k, word[k], r.word);
                        chk("nbits", k, nb[k], dw(k));
                        chk("busy_len", k, bcnt[k], xfer_len(k));
                        chk("cs_index", k, csi[k], r.cs);
                        chk("cs_stable", k, csbad[k], 0);
                        if (r.gap >= 0) chk("cs_gap", k, gapm[k], r.gap);
                    end
                end
            end
            if (!ended && done[k]) chk("done_outside_xfer", k, done[k], 0);
            if (err[k]) begin
                chk("err_expected", k, longint'(exp_err[k] > 0), 1);
                if (exp_err[k] > 0) exp_err[k]--;
                chk("err_busy", k, busy[k], 0);
                chk("err_cs", k, pcs[k], 4'hF);
            end
            idle_run[k] = (lows == 0) ? idle_run[k] + 1 : 0;
            prevc[k]    = pclk[k];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]      = 1'b1;
            start[k]    = 1'b0;
            csel[k]     = 3'd0;
            exp_err[k]  = 0;
            in_x[k]     = 1'b0;
            idle_run[k] = 0;
            prevc[k]    = cpol(k);
        end
        din_a = '0;
        din_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, busy[k], 0);
            chk("rst_done", k, done[k], 0);
            chk("rst_err", k, err[k], 0);
            chk("rst_pclk", k, pclk[k], cpol(k));
            chk("rst_pdata", k, pdata[k], 0);
            chk("rst_cs", k, pcs[k], 4'hF);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        send(0, 16'hA5C3, 3'd1);
        send(1, 16'h0081, 3'd0);
        send(0, 16'h1234, 3'd5);
        send(1, 16'h0042, 3'd7);

        repeat (10) begin
            send(int'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 5)));
        end

        // Second request during a transfer must be ignored entirely.
        @(posedge clk); #1;
        start[0] = 1'b1;
        set_in(0, 16'h0001, 3'd2);
        expect_xfer(0, 16'h0001, 2, 1'b0, -1);
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start[0] = 1'b1;
        set_in(0, 16'hFFFF, 3'd3);
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (xfer_len(0) + 3) @(posedge clk);

        // Reset in the middle of a transfer aborts it without a done pulse.
        @(posedge clk); #1;
        start[0] = 1'b1;
        set_in(0, 16'($urandom), 3'd3);
        expect_xfer(0, 16'h0, 3, 1'b1, -1);
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(posedge clk); #1;

        // Start held through reset release is taken on the first free edge.
        rst[0]   = 1'b1;
        start[0] = 1'b1;
        set_in(0, 16'h5A3C, 3'd0);
        expect_xfer(0, 16'h5A3C, 0, 1'b0, -1);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (xfer_len(0) + 3) @(posedge clk);

        back_to_back(1, 4);
        back_to_back(0, 2);

        repeat (10) @(posedge clk);
        chk("sb_empty", 0, sbq.size(), 0);
        chk("err_pending", 0, exp_err[0], 0);
        chk("err_pending", 1, exp_err[1], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peri_serial_tx.md
PERI_SERIAL_TX -- requirements
Module: peri_serial_tx

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the number of bits per transfer (2..32).
REQ-002 Parameter DIV, default 4, SHALL set the serial half-period in clock cycles (>=1).
REQ-003 Parameter NUM_CS, default 4, SHALL set the number of chip-select channels (1..8).
REQ-004 Parameter MSB_FIRST, default 1, SHALL send MSB first when 1 and LSB first when 0.
REQ-005 Parameter CPOL, default 0, SHALL set the idle level of P_CLOCK.
REQ-006 Port clock, input, 1: the single system clock; all logic SHALL be on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: transfer request, sampled each cycle.
REQ-009 Port data_in, input, DATA_W: word to transmit.
REQ-010 Port cs_sel, input, 3: index of the chip select to assert.
REQ-011 Port busy, output, 1: high while a transfer is in progress.
REQ-012 Port done, output, 1: one-cycle pulse when a transfer completes.
REQ-013 Port err, output, 1: one-cycle pulse when a request is rejected.
REQ-014 Port P_CLOCK, output, 1: serial clock.
REQ-015 Port P_DATA, output, 1: serial data.
REQ-016 Port P_CS, output, NUM_CS: chip selects, active-low.

Function
REQ-017 The FSM SHALL have the states IDLE, LEAD, BIT_IDLE, BIT_ACT and TRAIL.
REQ-018 In IDLE with start=1 and cs_sel<NUM_CS, the block SHALL latch data_in and cs_sel and enter LEAD; the next cycle SHALL show busy=1 and P_CS[cs_sel]=0.
REQ-019 In IDLE with start=1 and cs_sel>=NUM_CS, the block SHALL pulse err for one cycle, stay in IDLE and leave every P_CS bit high.
REQ-020 The block SHALL ignore start while busy=1, and SHALL change neither the latched data nor the latched cs_sel.
REQ-021 LEAD SHALL last DIV cycles with P_CLOCK=CPOL and P_DATA set to the first bit.
REQ-022 Each bit SHALL spend DIV cycles in BIT_IDLE (P_CLOCK=CPOL) followed by DIV cycles in BIT_ACT (P_CLOCK=~CPOL).
REQ-023 P_DATA SHALL change only on entry to BIT_IDLE, or in LEAD for the first bit, so it is stable across each CPOL->~CPOL edge, which is the receiver's sample edge.
REQ-024 After BIT_ACT of the last bit (bit counter reaches DATA_W-1), the FSM SHALL enter TRAIL for DIV cycles with P_CLOCK=CPOL and CS still asserted.
REQ-025 On leaving TRAIL the block SHALL enter IDLE, raise all P_CS, drive busy=0 and pulse done=1 for exactly that cycle.
REQ-026 busy SHALL stay high for exactly DIV*(2*DATA_W+2) cycles per transfer.
REQ-027 A start in the done cycle SHALL be accepted, giving back-to-back transfers with a CS-high gap of exactly 1 cycle.
REQ-028 The divider counter SHALL count 0..DIV-1 and wrap; the bit counter SHALL be ceil(log2(DATA_W)) bits wide and SHALL NOT wrap during a transfer.
REQ-029 At most one P_CS bit SHALL be low at any time.
REQ-030 In IDLE: P_CLOCK=CPOL, P_DATA=0, P_CS all ones.

Reset
REQ-031 With reset=1 at a clock edge, the next cycle SHALL show state IDLE, busy=0, done=0, err=0, P_CLOCK=CPOL, P_DATA=0, P_CS all ones, and all counters cleared.
REQ-032 Reset SHALL take priority over start, including mid-transfer; the aborted transfer SHALL NOT produce a done pulse.
REQ-033 start held high through reset release SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-034 Defaults with DIV=2; data_in=16'hA5C3, cs_sel=1, start pulse -> P_CS=4'b1101; the 16 bits sampled on the rising edges of P_CLOCK read 1010_0101_1100_0011; busy high for 68 cycles; done pulses in the following cycle.
REQ-035 MSB_FIRST=0, CPOL=1, DATA_W=8, DIV=1; data_in=8'h81, cs_sel=0 -> P_CLOCK idles high; bits sampled on falling edges read 1,0,0,0,0,0,0,1; busy high for 18 cycles.
REQ-036 start with cs_sel=5 and NUM_CS=4 -> err=1 for 1 cycle; P_CS stays 4'b1111 and busy stays 0.
REQ-037 A second start with data 16'hFFFF at cycle 10 of a 16'h0001 transfer -> ignored; the transmitted word is 16'h0001; only one done pulse.
REQ-038 reset asserted at cycle 20 of a transfer -> the next cycle shows P_CS all ones, busy=0, P_CLOCK=CPOL, and no done pulse.
REQ-039 start held high continuously (DIV=1, DATA_W=4) -> transfers run back-to-back; each transfer keeps CS low for 10 cycles, with CS high for 1 cycle between transfers.
